// File: rtl/cam_sccb_init.sv
// cam_sccb_init
//   Write-only SCCB master that loads a fixed OV7670 register table after
//   reset (RGB565, QQVGA 160x120, divided PCLK) and can replay it on request.
//   Each entry is written as one three-byte frame: 0x42, reg, val.
//
// Ports
//   clk        in   single clock for all logic
//   rst        in   asynchronous, active-low reset
//   start      in   one-cycle pulse; replays the table, honoured only in DONE
//   sioc       out  SCCB clock, push-pull, idle high
//   siod_oe    out  1 pulls SIOD low, 0 releases it (external pull-up)
//   busy       out  high from reset release to table end, and during a replay
//   done       out  high in DONE only
//   idx        out  index of the table entry in flight or last sent
//   dbg_state  out  current FSM state (state_t encoding)
//
// Parameters
//   CLK_HZ, SCCB_HZ  quarter-bit divider QDIV = CLK_HZ/(4*SCCB_HZ), must be >= 2
//   PWRUP_CYC        wait after reset release and after the soft-reset entry
//
// Build option
//   CAM_COLORBAR_EN  when defined, COM7=0x16 and SCALING_YSC=0xB5 select the
//                    8-bar colour test pattern; table length and timing unchanged.

module cam_sccb_init #(
   parameter int unsigned CLK_HZ    = 25000000,
   parameter int unsigned SCCB_HZ   = 100000,
   parameter int unsigned PWRUP_CYC = 25000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       sioc,
   output logic       siod_oe,
   output logic       busy,
   output logic       done,
   output logic [4:0] idx,
   output logic [2:0] dbg_state
);

   localparam int unsigned QDIV = CLK_HZ / (4 * SCCB_HZ);
   localparam int unsigned QW   = (QDIV > 1) ? $clog2(QDIV) : 1;
   localparam int unsigned CW   = $clog2(PWRUP_CYC + 1);

   localparam logic [QW-1:0] Q_LAST       = QW'(QDIV - 1);
   localparam logic [CW-1:0] PWRUP_LAST   = CW'(PWRUP_CYC);
   localparam logic [CW-1:0] RSTWAIT_LAST = CW'(PWRUP_CYC - 1);
   localparam logic [4:0]    LAST_IDX     = 5'd11;
   localparam logic [4:0]    LAST_BIT     = 5'd26;
   localparam logic [7:0]    DEV_ADDR     = 8'h42;
   localparam logic [15:0]   SOFT_RESET   = 16'h1280;

`ifdef CAM_COLORBAR_EN
   localparam logic [7:0] COM7_VAL = 8'h16;
   localparam logic [7:0] SCALY_VAL = 8'hB5;
`else
   localparam logic [7:0] COM7_VAL = 8'h14;
   localparam logic [7:0] SCALY_VAL = 8'h35;
`endif

   typedef enum logic [2:0] {
      S_PWRUP, S_START, S_BIT, S_STOP, S_GAP, S_RSTWAIT, S_NEXT, S_DONE
   } state_t;

   function automatic logic [15:0] table_entry(input logic [4:0] i);
      case (i)
         5'd0:    table_entry = SOFT_RESET;
         5'd1:    table_entry = {8'h12, COM7_VAL};
         5'd2:    table_entry = 16'h40D0;
         5'd3:    table_entry = 16'h8C00;
         5'd4:    table_entry = 16'h0C04;
         5'd5:    table_entry = 16'h3E1A;
         5'd6:    table_entry = 16'h703A;
         5'd7:    table_entry = {8'h71, SCALY_VAL};
         5'd8:    table_entry = 16'h7222;
         5'd9:    table_entry = 16'h73F2;
         5'd10:   table_entry = 16'hA202;
         5'd11:   table_entry = 16'h1101;
         default: table_entry = 16'h0000;
      endcase
   endfunction

   state_t        state_q, state_d;
   logic [QW-1:0] qdiv_q, qdiv_d;
   logic [1:0]    qtr_q, qtr_d;
   logic [4:0]    bit_q, bit_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [4:0]    idx_q, idx_d;
   logic          sioc_q, sioc_d;
   logic          siod_oe_q, siod_oe_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic          q_tick;
   logic [15:0]   entry;
   logic [26:0]   frame;

   always_comb begin
      state_d   = state_q;
      qdiv_d    = qdiv_q;
      qtr_d     = qtr_q;
      bit_d     = bit_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      sioc_d    = sioc_q;
      siod_oe_d = siod_oe_q;
      busy_d    = busy_q;
      done_d    = done_q;

      entry  = table_entry(idx_q);
      // The 9th bit of each byte is a 1 so SIOD is released for the slave's ACK.
      frame  = {DEV_ADDR, 1'b1, entry[15:8], 1'b1, entry[7:0], 1'b1};
      q_tick = (qdiv_q == Q_LAST);

      // The quarter divider only runs while a frame occupies the bus; it sits
      // at zero otherwise, so every frame state is entered on a quarter boundary.
      if ((state_q == S_START) || (state_q == S_BIT) ||
          (state_q == S_STOP)  || (state_q == S_GAP)) begin
         qdiv_d = q_tick ? '0 : qdiv_q + 1'b1;
         if (q_tick) qtr_d = qtr_q + 2'd1;
      end

      case (state_q)
         S_PWRUP: begin
            busy_d = 1'b1;
            if (cnt_q == PWRUP_LAST) begin
               cnt_d     = '0;
               siod_oe_d = 1'b1;          // START condition: SIOD falls, SIOC high
               state_d   = S_START;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_START: begin
            if (q_tick && (qtr_q == 2'd1)) begin
               sioc_d  = 1'b0;
               qtr_d   = '0;
               bit_d   = '0;
               state_d = S_BIT;
            end
         end
         S_BIT: begin
            // Data moves one cycle into quarter 0, when SIOC has been low for a
            // full cycle, so it never changes on the same edge SIOC falls.
            if ((qtr_q == 2'd0) && (qdiv_q == '0)) siod_oe_d = ~frame[LAST_BIT - bit_q];
            if (q_tick) begin
               case (qtr_q)
                  2'd0: sioc_d = 1'b1;
                  2'd2: sioc_d = 1'b0;
                  2'd3: begin
                     if (bit_q == LAST_BIT) state_d = S_STOP;
                     else bit_d = bit_q + 5'd1;
                  end
                  default: ;
               endcase
            end
         end
         S_STOP: begin
            if ((qtr_q == 2'd0) && (qdiv_q == '0)) siod_oe_d = 1'b1;
            if (q_tick) begin
               if (qtr_q == 2'd0) begin
                  sioc_d = 1'b1;
               end else if (qtr_q == 2'd1) begin
                  siod_oe_d = 1'b0;       // STOP condition: SIOD rises, SIOC high
               end else begin
                  qtr_d   = '0;
                  state_d = S_GAP;
               end
            end
         end
         S_GAP: begin
            if (q_tick && (qtr_q == 2'd3)) begin
               cnt_d   = '0;
               state_d = (entry == SOFT_RESET) ? S_RSTWAIT : S_NEXT;
            end
         end
         S_RSTWAIT: begin
            if (cnt_q == RSTWAIT_LAST) begin
               cnt_d   = '0;
               state_d = S_NEXT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_NEXT: begin
            // idx keeps pointing at the last entry once the table is finished.
            if (idx_q == LAST_IDX) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               idx_d     = idx_q + 5'd1;
               siod_oe_d = 1'b1;
               state_d   = S_START;
            end
         end
         S_DONE: begin
            if (start) begin
               idx_d     = '0;
               busy_d    = 1'b1;
               done_d    = 1'b0;
               siod_oe_d = 1'b1;
               state_d   = S_START;
            end
         end
         default: state_d = S_PWRUP;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_PWRUP;
         qdiv_q    <= '0;
         qtr_q     <= '0;
         bit_q     <= '0;
         cnt_q     <= '0;
         idx_q     <= '0;
         sioc_q    <= 1'b1;
         siod_oe_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         qdiv_q    <= qdiv_d;
         qtr_q     <= qtr_d;
         bit_q     <= bit_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         sioc_q    <= sioc_d;
         siod_oe_q <= siod_oe_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign sioc      = sioc_q;
   assign siod_oe   = siod_oe_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign idx       = idx_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_cam_sccb_init.sv
// tb_cam_sccb_init
//   Self-checking bench for cam_sccb_init. An I2C-style bus monitor decodes
//   every frame on SIOC/SIOD; expected frames and cycle counts come from the
//   register table and the per-transaction timing rules, computed here.

module tb_cam_sccb_init;

   localparam int CLK_HZ     = 4000000;
   localparam int SCCB_HZ    = 100000;
   localparam int PWRUP_CYC  = 100;
   localparam int QDIV       = CLK_HZ / (4 * SCCB_HZ);
   localparam int N_ENT      = 12;
   localparam int TXN_CYC    = 117 * QDIV;
   localparam int RUN_BUDGET = 20000;

`ifdef CAM_COLORBAR_EN
   localparam logic [7:0] EXP_COM7  = 8'h16;
   localparam logic [7:0] EXP_SCALY = 8'hB5;
`else
   localparam logic [7:0] EXP_COM7  = 8'h14;
   localparam logic [7:0] EXP_SCALY = 8'h35;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic       clk;
   logic       rst;
   logic       start;
   logic       sioc;
   logic       siod_oe;
   logic       busy;
   logic       done;
   logic [4:0] idx;
   logic [2:0] dbg_state;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   cam_sccb_init #(
      .CLK_HZ(CLK_HZ), .SCCB_HZ(SCCB_HZ), .PWRUP_CYC(PWRUP_CYC)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .sioc(sioc), .siod_oe(siod_oe),
      .busy(busy), .done(done), .idx(idx), .dbg_state(dbg_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model ----------------
   logic [15:0] ref_tbl [N_ENT];
   logic [23:0] exp_q[$];

   function automatic void build_model();
      ref_tbl[0]  = 16'h1280;
      ref_tbl[1]  = {8'h12, EXP_COM7};
      ref_tbl[2]  = 16'h40D0;
      ref_tbl[3]  = 16'h8C00;
      ref_tbl[4]  = 16'h0C04;
      ref_tbl[5]  = 16'h3E1A;
      ref_tbl[6]  = 16'h703A;
      ref_tbl[7]  = {8'h71, EXP_SCALY};
      ref_tbl[8]  = 16'h7222;
      ref_tbl[9]  = 16'h73F2;
      ref_tbl[10] = 16'hA202;
      ref_tbl[11] = 16'h1101;
   endfunction

   function automatic void load_expected();
      exp_q.delete();
      for (int i = 0; i < N_ENT; i++) exp_q.push_back({8'h42, ref_tbl[i]});
   endfunction

   // Cycles from one START to the next: frame, one NEXT cycle, plus the
   // soft-reset settling wait after the 0x12<-0x80 entry.
   function automatic int entry_cycles(input int i);
      return TXN_CYC + 1 + ((ref_tbl[i] == 16'h1280) ? PWRUP_CYC : 0);
   endfunction

   function automatic int run_cycles();
      int total = 0;
      for (int i = 0; i < N_ENT; i++) total += entry_cycles(i);
      return total;
   endfunction

   // ---------------- bus monitor ----------------
   logic [23:0] txn_q[$];
   int          fall_q[$];
   int          viol_cnt;
   int          ack_err_cnt;
   int          done_cyc;
   logic        mon_in_frame;
   int          mon_bits;
   logic [23:0] mon_sh;
   logic        mon_sda;
   logic        prev_sioc;
   logic        prev_sda;
   logic        prev_done;

   always @(negedge clk) begin
      mon_sda = ~siod_oe;
      if (!rst) begin
         mon_in_frame = 1'b0;
         mon_bits     = 0;
         mon_sh       = '0;
         prev_sioc    = 1'b1;
         prev_sda     = 1'b1;
         prev_done    = 1'b0;
      end else begin
         if (sioc && prev_sioc && (mon_sda != prev_sda)) begin
            if (!mon_sda) begin
               if (mon_in_frame) viol_cnt++;
               mon_in_frame = 1'b1;
               mon_bits     = 0;
               mon_sh       = '0;
               fall_q.push_back(cyc);
            end else begin
               if (!mon_in_frame || (mon_bits != 27)) viol_cnt++;
               else txn_q.push_back(mon_sh);
               mon_in_frame = 1'b0;
            end
         end else if (sioc && !prev_sioc && mon_in_frame && (mon_bits < 27)) begin
            if ((mon_bits % 9) == 8) begin
               if (mon_sda !== 1'b1) ack_err_cnt++;
            end else begin
               mon_sh = {mon_sh[22:0], mon_sda};
            end
            mon_bits++;
         end
         if (done && !prev_done) done_cyc = cyc;
         prev_sioc = sioc;
         prev_sda  = mon_sda;
         prev_done = done;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_monitor();
      txn_q.delete();
      fall_q.delete();
      viol_cnt    = 0;
      ack_err_cnt = 0;
      done_cyc    = -1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst   = 1'b0;
      start = 1'b0;
      repeat (3) tick();
      n_tests++; if (sioc !== 1'b1)    begin n_fail++; $display("FAIL reset_sioc: got %b want 1", sioc); end
      n_tests++; if (siod_oe !== 1'b0) begin n_fail++; $display("FAIL reset_siod_oe: got %b want 0", siod_oe); end
      n_tests++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_tests++; if (done !== 1'b0)    begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
      n_tests++; if (idx !== 5'd0)     begin n_fail++; $display("FAIL reset_idx: got %0d want 0", idx); end
   endtask

   task automatic test_first_frame();
      int busy_cyc;
      int delay;
      bit ok;
      clear_monitor();
      rst = 1'b1;
      tick();
      busy_cyc = cyc;
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL first_busy: got %b want 1", busy); end

      ok = 1'b0;
      for (int i = 0; i < PWRUP_CYC + 20; i++) begin
         if (fall_q.size() > 0) begin ok = 1'b1; break; end
         tick();
      end
      delay = ok ? (fall_q[0] - busy_cyc) : -1;
      n_tests++;
      if (delay != PWRUP_CYC) begin n_fail++; $display("FAIL pwrup_delay: got %0d want %0d", delay, PWRUP_CYC); end

      ok = 1'b0;
      for (int i = 0; i < TXN_CYC + PWRUP_CYC + 50; i++) begin
         if ((txn_q.size() > 0) && (fall_q.size() > 1)) begin ok = 1'b1; break; end
         tick();
      end
      n_tests++;
      if (!ok) begin
         n_fail++; $display("FAIL first_frame_wait: got timeout want two STARTs");
      end else begin
         n_tests++;
         if (txn_q[0] !== {8'h42, ref_tbl[0]}) begin
            n_fail++; $display("FAIL first_frame_bytes: got %h want %h", txn_q[0], {8'h42, ref_tbl[0]});
         end
         n_tests++;
         if ((fall_q[1] - fall_q[0]) != entry_cycles(0)) begin
            n_fail++; $display("FAIL rstwait_gap: got %0d want %0d", fall_q[1] - fall_q[0], entry_cycles(0));
         end
      end
   endtask

   task automatic test_ignored_start();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < RUN_BUDGET; i++) begin
         if ((idx == 5'd4) && busy) begin ok = 1'b1; break; end
         tick();
      end
      n_tests++; if (!ok) begin n_fail++; $display("FAIL ignored_wait: got timeout want idx 4"); end
      repeat ($urandom_range(0, TXN_CYC - 100)) tick();
      pulse_start();
      n_tests++; if (idx !== 5'd4) begin n_fail++; $display("FAIL ignored_idx: got %0d want 4", idx); end
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ignored_busy: got %b want 1", busy); end
   endtask

   task automatic test_full_run();
      bit ok;
      logic [23:0] got;
      logic [23:0] want;
      int first;
      ok = 1'b0;
      for (int i = 0; i < RUN_BUDGET; i++) begin
         if (done) begin ok = 1'b1; break; end
         tick();
      end
      n_tests++; if (!ok) begin n_fail++; $display("FAIL full_done_wait: got timeout want done"); end
      load_expected();
      n_tests++;
      if (txn_q.size() != N_ENT) begin n_fail++; $display("FAIL full_count: got %0d want %0d", txn_q.size(), N_ENT); end
      for (int i = 0; i < N_ENT; i++) begin
         want = exp_q.pop_front();
         if (txn_q.size() > 0) got = txn_q.pop_front();
         else got = 'x;
         n_tests++;
         if (got !== want) begin n_fail++; $display("FAIL full_frame%0d: got %h want %h", i, got, want); end
      end
      first = (fall_q.size() > 0) ? fall_q[0] : -1;
      n_tests++;
      if ((done_cyc - first) != run_cycles()) begin
         n_fail++; $display("FAIL full_done_time: got %0d want %0d", done_cyc - first, run_cycles());
      end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL full_busy: got %b want 0", busy); end
      n_tests++; if (idx !== 5'd11) begin n_fail++; $display("FAIL full_idx: got %0d want 11", idx); end
      n_tests++; if (viol_cnt != 0) begin n_fail++; $display("FAIL full_bus_rules: got %0d want 0", viol_cnt); end
      n_tests++; if (ack_err_cnt != 0) begin n_fail++; $display("FAIL full_ack_release: got %0d want 0", ack_err_cnt); end
   endtask

   task automatic test_replay();
      bit ok;
      int c1;
      int delay;
      logic [23:0] got;
      logic [23:0] want;
      repeat ($urandom_range(1, 40)) tick();
      clear_monitor();
      c1 = cyc + 1;
      pulse_start();
      n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL replay_done: got %b want 0", done); end
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL replay_busy: got %b want 1", busy); end
      n_tests++; if (idx !== 5'd0) begin n_fail++; $display("FAIL replay_idx: got %0d want 0", idx); end
      ok = 1'b0;
      for (int i = 0; i < QDIV + 5; i++) begin
         if (fall_q.size() > 0) begin ok = 1'b1; break; end
         tick();
      end
      delay = ok ? (fall_q[0] - c1) : -1;
      n_tests++;
      if ((delay < 0) || (delay > QDIV)) begin n_fail++; $display("FAIL replay_fall: got %0d want 0..%0d", delay, QDIV); end

      ok = 1'b0;
      for (int i = 0; i < RUN_BUDGET; i++) begin
         if (done) begin ok = 1'b1; break; end
         tick();
      end
      n_tests++; if (!ok) begin n_fail++; $display("FAIL replay_done_wait: got timeout want done"); end
      load_expected();
      n_tests++;
      if (txn_q.size() != N_ENT) begin n_fail++; $display("FAIL replay_count: got %0d want %0d", txn_q.size(), N_ENT); end
      for (int i = 0; i < N_ENT; i++) begin
         want = exp_q.pop_front();
         if (txn_q.size() > 0) got = txn_q.pop_front();
         else got = 'x;
         n_tests++;
         if (got !== want) begin n_fail++; $display("FAIL replay_frame%0d: got %h want %h", i, got, want); end
      end
      if (fall_q.size() > 1) begin
         n_tests++;
         if ((fall_q[1] - fall_q[0]) != entry_cycles(0)) begin
            n_fail++; $display("FAIL replay_rstwait: got %0d want %0d", fall_q[1] - fall_q[0], entry_cycles(0));
         end
         n_tests++;
         if ((done_cyc - fall_q[0]) != run_cycles()) begin
            n_fail++; $display("FAIL replay_done_time: got %0d want %0d", done_cyc - fall_q[0], run_cycles());
         end
      end else begin
         n_tests++; n_fail++; $display("FAIL replay_starts: got %0d want %0d", fall_q.size(), N_ENT);
      end
      n_tests++; if (viol_cnt != 0) begin n_fail++; $display("FAIL replay_bus_rules: got %0d want 0", viol_cnt); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int target;
      int busy_cyc;
      int first;
      logic [23:0] got;
      logic [23:0] want;
      repeat ($urandom_range(1, 20)) tick();
      clear_monitor();
      pulse_start();
      // Wait for the clock of a bit inside the third byte, then into its low phase.
      target = 19 + int'($urandom_range(0, 7));
      ok = 1'b0;
      for (int i = 0; i < TXN_CYC + 50; i++) begin
         if (mon_in_frame && (mon_bits == target)) begin ok = 1'b1; break; end
         tick();
      end
      for (int i = 0; i < 4 * QDIV; i++) begin
         if (!sioc) break;
         tick();
      end
      n_tests++;
      if (!ok || sioc) begin n_fail++; $display("FAIL midreset_wait: got bits %0d sioc %b want bit %0d low", mon_bits, sioc, target); end
      repeat ($urandom_range(0, QDIV)) tick();
      #1 rst = 1'b0;
      #1;
      n_tests++; if (sioc !== 1'b1)    begin n_fail++; $display("FAIL midreset_sioc: got %b want 1", sioc); end
      n_tests++; if (siod_oe !== 1'b0) begin n_fail++; $display("FAIL midreset_siod_oe: got %b want 0", siod_oe); end
      n_tests++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL midreset_busy: got %b want 0", busy); end
      n_tests++; if (idx !== 5'd0)     begin n_fail++; $display("FAIL midreset_idx: got %0d want 0", idx); end
      repeat (3) tick();
      clear_monitor();
      rst = 1'b1;
      tick();
      busy_cyc = cyc;
      ok = 1'b0;
      for (int i = 0; i < RUN_BUDGET; i++) begin
         if (done) begin ok = 1'b1; break; end
         tick();
      end
      n_tests++; if (!ok) begin n_fail++; $display("FAIL midreset_done_wait: got timeout want done"); end
      first = (fall_q.size() > 0) ? fall_q[0] : -1;
      n_tests++;
      if ((first - busy_cyc) != PWRUP_CYC) begin n_fail++; $display("FAIL midreset_pwrup: got %0d want %0d", first - busy_cyc, PWRUP_CYC); end
      n_tests++;
      if ((done_cyc - first) != run_cycles()) begin n_fail++; $display("FAIL midreset_done_time: got %0d want %0d", done_cyc - first, run_cycles()); end
      load_expected();
      n_tests++;
      if (txn_q.size() != N_ENT) begin n_fail++; $display("FAIL midreset_count: got %0d want %0d", txn_q.size(), N_ENT); end
      for (int i = 0; i < N_ENT; i++) begin
         want = exp_q.pop_front();
         if (txn_q.size() > 0) got = txn_q.pop_front();
         else got = 'x;
         n_tests++;
         if (got !== want) begin n_fail++; $display("FAIL midreset_frame%0d: got %h want %h", i, got, want); end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst   = 1'b0;
      start = 1'b0;
      build_model();
      clear_monitor();
      test_reset();
      test_first_frame();
      test_ignored_start();
      test_full_run();
      test_replay();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
